mc8051_ucode_seq: RTL and testbench

- Registered, multi-stage microcode sequencer for the mc8051 core.
- Replaces the purely combinational opcode decoder: accepts an opcode, walks its microcode stages (up to 2^STAGE_W), and issues one microcode word per stage. It advances on the bus-stage completion tick.
- The microcode table is a writable RAM indexed by {stage, opcode}. Undefined entries raise an illegal-opcode trap.
- Sits between the instruction fetch buffer and the datapath/bus controller.

---
 rtl/mc8051_ucode_seq_pkg.sv | 15 +
 rtl/mc8051_ucode_ram.sv | 44 ++++
 rtl/mc8051_ucode_seq.sv | 134 +++++++++++++
 tb/tb_mc8051_ucode_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc8051_ucode_seq_pkg.sv
// Shared defaults and FSM state type for the mc8051 microcode sequencer.
package mc8051_ucode_seq_pkg;

  localparam int unsigned MC_WIDTH_DEF = 64;
  localparam int unsigned OP_W_DEF     = 8;
  localparam int unsigned STG_W_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mc8051_ucode_ram.sv
// Single-write/single-read synchronous microcode RAM with per-entry valid flags.
module mc8051_ucode_ram
  import mc8051_ucode_seq_pkg::*;
#(
  parameter int unsigned DW = MC_WIDTH_DEF,
  parameter int unsigned AW = OP_W_DEF + STG_W_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_wvalid,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  output logic          o_rvalid
);

  logic [DW-1:0]      mem_q [2**AW];
  logic [2**AW-1:0]   vld_q;
  logic [DW-1:0]      rdata_q;
  logic               rvalid_q;

  // Data words are never reset; only the valid flags are.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (i_we) vld_q[i_waddr] <= i_wvalid;
      if (i_re) rvalid_q <= vld_q[i_raddr];
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;

endmodule

// File: rtl/mc8051_ucode_seq.sv
// Registered microcode sequencer: walks the stages of an accepted opcode and
// issues one table word per stage, trapping on undefined entries or overflow.
module mc8051_ucode_seq
  import mc8051_ucode_seq_pkg::*;
#(
  parameter  int unsigned MCODE_WIDTH = MC_WIDTH_DEF,
  parameter  int unsigned OPCODE_W    = OP_W_DEF,
  parameter  int unsigned STAGE_W     = STG_W_DEF,
  localparam int unsigned TBL_AW      = STAGE_W + OPCODE_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_op_valid,
  input  logic [OPCODE_W-1:0]    i_opcode,
  output logic                   o_op_ready,
  input  logic                   i_stage_done,
  input  logic                   i_flush,
  output logic [MCODE_WIDTH-1:0] o_mc_b,
  output logic                   o_mc_valid,
  output logic [STAGE_W-1:0]     o_ci_stage,
  output logic                   o_instr_done,
  output logic                   o_illegal,
  output logic [OPCODE_W-1:0]    o_illegal_op,
  input  logic                   i_tbl_we,
  input  logic [TBL_AW-1:0]      i_tbl_addr,
  input  logic [MCODE_WIDTH:0]   i_tbl_wdata
);

  localparam int unsigned MORE_BIT = MCODE_WIDTH - 1;

  seq_state_e            state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [OPCODE_W-1:0]   ill_op_q, ill_op_d;

  logic [MCODE_WIDTH-1:0] rd_data;
  logic                   rd_valid;
  logic                   rd_en;
  logic                   exec_ok;
  logic                   more;
  logic                   last_stage;
  logic                   fin;
  logic                   accept;

  mc8051_ucode_ram #(
    .DW (MCODE_WIDTH),
    .AW (TBL_AW)
  ) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (i_tbl_we),
    .i_waddr  (i_tbl_addr),
    .i_wdata  (i_tbl_wdata[MCODE_WIDTH-1:0]),
    .i_wvalid (i_tbl_wdata[MCODE_WIDTH]),
    .i_re     (rd_en),
    .i_raddr  ({stage_q, opcode_q}),
    .o_rdata  (rd_data),
    .o_rvalid (rd_valid)
  );

  assign rd_en      = (state_q == ST_FETCH);
  assign exec_ok    = (state_q == ST_EXEC) && rd_valid;
  assign more       = rd_data[MORE_BIT];
  assign last_stage = &stage_q;
  assign fin        = exec_ok && i_stage_done && !more;

  // Ready also covers the final-stage completion so the next opcode is taken without an IDLE bubble.
  assign o_op_ready = !i_flush && ((state_q == ST_IDLE) || fin);
  assign accept     = o_op_ready && i_op_valid;

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    opcode_d = opcode_q;
    ill_op_d = ill_op_q;
    if (i_flush) begin
      state_d = ST_IDLE;
      stage_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC: begin
          if (!rd_valid) begin
            state_d = ST_TRAP;
          end else if (i_stage_done) begin
            if (!more) begin
              state_d = ST_IDLE;
              stage_d = '0;
            end else if (last_stage) begin
              state_d = ST_TRAP;
            end else begin
              stage_d = stage_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          state_d = ST_IDLE;
          stage_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        opcode_d = i_opcode;
        stage_d  = '0;
        state_d  = ST_FETCH;
      end
      if (state_d == ST_TRAP) ill_op_d = opcode_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      opcode_q <= '0;
      ill_op_q <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      opcode_q <= opcode_d;
      ill_op_q <= ill_op_d;
    end
  end

  assign o_mc_valid   = exec_ok;
  assign o_mc_b       = exec_ok ? rd_data : '0;
  assign o_ci_stage   = stage_q;
  assign o_instr_done = fin && !i_flush;
  assign o_illegal    = (state_q == ST_TRAP);
  assign o_illegal_op = ill_op_q;

endmodule

// File: tb/tb_mc8051_ucode_seq.sv
// Self-checking bench for mc8051_ucode_seq against a table-driven instruction model.
module tb_mc8051_ucode_seq;

  localparam int MW = 64;
  localparam int OW = 8;
  localparam int SW = 2;
  localparam int AW = SW + OW;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_op_valid;
  logic [OW-1:0] i_opcode;
  logic          o_op_ready;
  logic          i_stage_done;
  logic          i_flush;
  logic [MW-1:0] o_mc_b;
  logic          o_mc_valid;
  logic [SW-1:0] o_ci_stage;
  logic          o_instr_done;
  logic          o_illegal;
  logic [OW-1:0] o_illegal_op;
  logic          i_tbl_we;
  logic [AW-1:0] i_tbl_addr;
  logic [MW:0]   i_tbl_wdata;

  always #5 i_clk = ~i_clk;

  mc8051_ucode_seq #(
    .MCODE_WIDTH (MW),
    .OPCODE_W    (OW),
    .STAGE_W     (SW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_op_valid   (i_op_valid),
    .i_opcode     (i_opcode),
    .o_op_ready   (o_op_ready),
    .i_stage_done (i_stage_done),
    .i_flush      (i_flush),
    .o_mc_b       (o_mc_b),
    .o_mc_valid   (o_mc_valid),
    .o_ci_stage   (o_ci_stage),
    .o_instr_done (o_instr_done),
    .o_illegal    (o_illegal),
    .o_illegal_op (o_illegal_op),
    .i_tbl_we     (i_tbl_we),
    .i_tbl_addr   (i_tbl_addr),
    .i_tbl_wdata  (i_tbl_wdata)
  );

  // Reference table: {entry_valid, word} per {stage, opcode}.
  logic [MW:0] m_tbl [1 << AW];
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge i_clk);
  endtask

  task automatic tbl_write(input logic [SW-1:0] s, input logic [OW-1:0] op,
                           input logic v, input logic [MW-1:0] w);
    i_tbl_we    = 1'b1;
    i_tbl_addr  = {s, op};
    i_tbl_wdata = {v, w};
    tick();
    i_tbl_we = 1'b0;
    m_tbl[{s, op}] = {v, w};
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"},    64'(o_op_ready),   64'd1);
    check_eq({tag, "_mc_b"},     o_mc_b,            64'd0);
    check_eq({tag, "_mc_valid"}, 64'(o_mc_valid),   64'd0);
    check_eq({tag, "_stage"},    64'(o_ci_stage),   64'd0);
    check_eq({tag, "_done"},     64'(o_instr_done), 64'd0);
    check_eq({tag, "_illegal"},  64'(o_illegal),    64'd0);
    check_eq({tag, "_ill_op"},   64'(o_illegal_op), 64'd0);
  endtask

  task automatic idle_check();
    settle();
    check_eq("idle_ready",    64'(o_op_ready), 64'd1);
    check_eq("idle_mc_valid", 64'(o_mc_valid), 64'd0);
    check_eq("idle_illegal",  64'(o_illegal),  64'd0);
    tick();
  endtask

  task automatic check_trap(input logic [OW-1:0] op);
    settle();
    check_eq("trap_illegal",  64'(o_illegal),    64'd1);
    check_eq("trap_op",       64'(o_illegal_op), 64'(op));
    check_eq("trap_mc_valid", 64'(o_mc_valid),   64'd0);
    check_eq("trap_mc_b",     o_mc_b,            64'd0);
    tick();
  endtask

  task automatic accept(input logic [OW-1:0] op);
    i_op_valid = 1'b1;
    i_opcode   = op;
    settle();
    check_eq("accept_ready", 64'(o_op_ready), 64'd1);
    tick();
    i_op_valid = 1'b0;
  endtask

  // Runs an already-accepted opcode from its first FETCH cycle to completion.
  task automatic run_body(input logic [OW-1:0] op, input bit chain,
                          input logic [OW-1:0] nop, output bit chained);
    logic [MW:0] e;
    bit          mr;
    chained = 1'b0;
    for (int unsigned s = 0; s < 4; s++) begin
      settle();
      check_eq("fetch_mc_valid", 64'(o_mc_valid),   64'd0);
      check_eq("fetch_done",     64'(o_instr_done), 64'd0);
      tick();
      e = m_tbl[{2'(s), op}];
      if (!e[MW]) begin
        settle();
        check_eq("undef_mc_valid", 64'(o_mc_valid), 64'd0);
        check_eq("undef_illegal",  64'(o_illegal),  64'd0);
        tick();
        check_trap(op);
        idle_check();
        return;
      end
      mr = e[MW-1];
      repeat ($urandom_range(0, 2)) begin
        settle();
        check_eq("exec_mc_valid", 64'(o_mc_valid),   64'd1);
        check_eq("exec_mc_b",     o_mc_b,            e[MW-1:0]);
        check_eq("exec_stage",    64'(o_ci_stage),   64'(s));
        check_eq("exec_done",     64'(o_instr_done), 64'd0);
        tick();
      end
      i_stage_done = 1'b1;
      if (chain && !mr) begin
        i_op_valid = 1'b1;
        i_opcode   = nop;
      end
      settle();
      check_eq("sdone_mc_valid", 64'(o_mc_valid),   64'd1);
      check_eq("sdone_mc_b",     o_mc_b,            e[MW-1:0]);
      check_eq("sdone_stage",    64'(o_ci_stage),   64'(s));
      check_eq("sdone_done",     64'(o_instr_done), 64'(!mr));
      check_eq("sdone_ready",    64'(o_op_ready),   64'(!mr));
      tick();
      i_stage_done = 1'b0;
      i_op_valid   = 1'b0;
      if (!mr) begin
        chained = chain;
        if (!chain) idle_check();
        return;
      end
      if (s == 3) begin
        check_trap(op);
        idle_check();
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [OW-1:0] op);
    bit ch;
    accept(op);
    run_body(op, 1'b0, '0, ch);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] op, nop;
    logic [MW-1:0] w;
    bit            ch, chain;

    for (int i = 0; i < (1 << AW); i++) m_tbl[i] = '0;
    i_rst = 1'b1;
    i_op_valid = 1'b0; i_opcode = '0; i_stage_done = 1'b0; i_flush = 1'b0;
    i_tbl_we = 1'b0; i_tbl_addr = '0; i_tbl_wdata = '0;
    settle();
    check_reset_vals("rst");
    tick();
    i_rst = 1'b0;

    // Single-stage, two-stage, undefined opcode, stage overflow.
    tbl_write(2'd0, 8'h74, 1'b1, 64'h0123);
    run_instr(8'h74);
    tbl_write(2'd0, 8'hA4, 1'b1, {1'b1, 63'h0AAA});
    tbl_write(2'd1, 8'hA4, 1'b1, 64'h0BBB);
    run_instr(8'hA4);
    run_instr(8'hA5);
    for (int s = 0; s < 4; s++) tbl_write(2'(s), 8'h10, 1'b1, {1'b1, 63'(s + 16)});
    run_instr(8'h10);

    // Back-to-back 0x00 then 0x74.
    tbl_write(2'd0, 8'h00, 1'b1, 64'h0F00);
    accept(8'h00);
    run_body(8'h00, 1'b1, 8'h74, ch);
    if (ch) run_body(8'h74, 1'b0, '0, ch);

    // Flush together with stage_done and op_valid in stage 1 of 0xA4.
    accept(8'hA4);
    settle(); tick();
    i_stage_done = 1'b1;
    settle();
    check_eq("fl_s0_mc_b", o_mc_b, {1'b1, 63'h0AAA});
    tick();
    i_stage_done = 1'b0;
    settle(); tick();
    i_flush = 1'b1; i_stage_done = 1'b1; i_op_valid = 1'b1; i_opcode = 8'h74;
    settle();
    check_eq("fl_stage",    64'(o_ci_stage),   64'd1);
    check_eq("fl_no_done",  64'(o_instr_done), 64'd0);
    check_eq("fl_no_ready", 64'(o_op_ready),   64'd0);
    tick();
    i_flush = 1'b0; i_stage_done = 1'b0; i_op_valid = 1'b0;
    settle();
    check_eq("fl_idle_valid",   64'(o_mc_valid), 64'd0);
    check_eq("fl_idle_ready",   64'(o_op_ready), 64'd1);
    check_eq("fl_idle_stage",   64'(o_ci_stage), 64'd0);
    check_eq("fl_idle_illegal", 64'(o_illegal),  64'd0);
    tick();

    // Randomised opcodes over a small pool, with random table rewrites and chaining.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = {$urandom, $urandom};
        w[MW-1] = ($urandom_range(0, 1) == 1);
        tbl_write(2'($urandom_range(0, 3)), 8'(8'h20 + $urandom_range(0, 5)),
                  ($urandom_range(0, 6) != 0), w);
      end
      op = 8'(8'h20 + $urandom_range(0, 7));
      chain = ($urandom_range(0, 1) == 1);
      accept(op);
      do begin
        nop = 8'(8'h20 + $urandom_range(0, 7));
        run_body(op, chain, nop, ch);
        op = nop;
        chain = ($urandom_range(0, 1) == 1);
      end while (ch);
    end

    // Asynchronous reset in the middle of EXEC; the entry must be undefined afterwards.
    accept(8'h74);
    settle(); tick();
    settle();
    check_eq("pre_rst_valid", 64'(o_mc_valid), 64'd1);
    #1;
    i_rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    for (int i = 0; i < (1 << AW); i++) m_tbl[i][MW] = 1'b0;
    tick();
    i_rst = 1'b0;
    run_instr(8'h74);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
